wb_trace_checker: RTL and testbench
===================================

Name: wb_trace_checker

Overview:
- Synthesizable, self-checking writeback monitor for the openMIPS core.
- Generalises the fixed-schedule register/HI/LO assertions used in instruction tests into an event-ordered checker.
- Holds a loadable expected-event trace and compares it in order against the core's GPR and HI/LO writeback streams, independent of pipeline timing.
- Sits beside openmips_min_sopc and reports pass/fail with a failure index, cause and values.

Parameters:
DATA_W, 32, data width of GPR/HI/LO writes
ADDR_W, 5, GPR address width
DEPTH, 64, trace entries (power of two)
IDX_W, 6, log2(DEPTH)
TIMEOUT, 256, max consecutive event-free RUN cycles before failure
TO_W, 9, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  reset
load_we  in  1  append load_data to trace
load_data  in  2+ADDR_W+DATA_W  {kind[1:0], addr, data}; kind 0=GPR 1=HI 2=LO 3=END
start  in  1  begin/restart check
wb_wreg  in  1  GPR write valid
wb_wd  in  ADDR_W  GPR write address
wb_wdata  in  DATA_W  GPR write data
wb_whilo  in  1  HI/LO write valid
wb_hi  in  DATA_W  HI write data
wb_lo  in  DATA_W  LO write data
busy  out  1  state==RUN
done  out  1  PASS or FAIL reached
pass  out  1  check passed
load_ovf  out  1  load attempted with trace full
fail_cause  out  2  0 none, 1 mismatch, 2 extra event, 3 timeout
fail_idx  out  IDX_W  trace index of failure
fail_got  out  DATA_W  observed data at failure
fail_exp  out  DATA_W  expected data at failure

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - state=IDLE; wptr, rptr, timeout counter = 0.
  - All outputs 0.
  - Trace memory contents are not cleared but are unreachable (wptr=0).
- States are IDLE, RUN, PASS, FAIL.

IDLE:
- load_we writes mem[wptr], wptr++.
- At wptr==DEPTH, the write is dropped and load_ovf sets (sticky until rst).
- load_we is ignored outside IDLE.
- start -> RUN next cycle with rptr=0 and counter=0. Writeback inputs in the start cycle are ignored.

RUN, per cycle:
- Event list E is built in fixed order:
  - GPR, if wb_wreg && wb_wd!=0 (writes to $0 are not events);
  - then HI, if wb_whilo;
  - then LO, if wb_whilo.
- n=|E| is 0..3.
- Each E[k] is compared with mem[rptr+k]. A match requires equal kind, equal data, and equal addr for GPR entries only.
- If rptr+k>=wptr or the entry kind is END -> cause 2 (extra event).
- If any k fails, the first failing k wins:
  - FAIL next cycle;
  - fail_idx=rptr+k, fail_got=E[k] data, fail_exp=entry data (0 for extra).
- Otherwise rptr+=n and the counter clears if n>0.
- If n==0 and (rptr==wptr or mem[rptr].kind==END) -> PASS next cycle.
- If n==0 and not finished -> counter++. When the counter reaches TIMEOUT -> FAIL with cause 3, fail_idx=rptr, got/exp=0.
- The empty-trace case (wptr=0) passes on the first RUN cycle with no events.

PASS/FAIL:
- done=1. pass=1 only in PASS. Failure fields are held.
- start restarts RUN against the same trace and clears done, pass and the failure fields.
- Loading additional entries requires rst.

Simultaneous events and reset:
- rst has priority over everything.
- start while in RUN is ignored.
- Reset mid-RUN -> IDLE with the reset values above on the next edge.

Test Plan:
- Load {GPR r1=1, GPR r1=2, GPR r3=5, END}, start, drive the matching writes with 0-4 idle cycles between them -> pass=1, done=1 one cycle after the cycle with no event following the r3 write; fail_cause=0.
- Same trace, third write r3=6 -> FAIL; fail_cause=1, fail_idx=2, fail_got=6, fail_exp=5, pass=0.
- Load {GPR r1=3, HI=2, LO=0xE, END}; in one cycle drive wb_wreg r1=3 together with wb_whilo hi=2, lo=0xE -> all three entries consumed, PASS. Swapping the trace order of HI and GPR -> fail_cause=1, fail_idx=0.
- TIMEOUT=8, load {GPR r1=1, END}, start, no events -> FAIL on the cycle after the 8th idle cycle; fail_cause=3, fail_idx=0.
- Write to $0 with data 0x55 mid-trace -> ignored. After the trace is fully consumed, a GPR r2 write -> fail_cause=2, fail_idx=index of END, fail_got=write data, fail_exp=0.
- Load DEPTH+1 entries -> load_ovf=1, last entry dropped. Then assert rst mid-RUN -> all outputs 0 next cycle and wptr=0; a new load and run behaves as from cold.

Source files
------------

// File: rtl/wb_trace_checker.sv
// Writeback trace checker for the openMIPS core.
// Holds an expected sequence of GPR/HI/LO writes and consumes it in order
// against the live writeback streams, independent of pipeline timing.
// Reports pass/fail with the failing trace index, cause and data values.
module wb_trace_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 64,
    parameter int IDX_W   = 6,
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_we,
    input  logic [2+ADDR_W+DATA_W-1:0] load_data,
    input  logic                       start,
    input  logic                       wb_wreg,
    input  logic [ADDR_W-1:0]          wb_wd,
    input  logic [DATA_W-1:0]          wb_wdata,
    input  logic                       wb_whilo,
    input  logic [DATA_W-1:0]          wb_hi,
    input  logic [DATA_W-1:0]          wb_lo,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       load_ovf,
    output logic [1:0]                 fail_cause,
    output logic [IDX_W-1:0]           fail_idx,
    output logic [DATA_W-1:0]          fail_got,
    output logic [DATA_W-1:0]          fail_exp
);

    // Pointers carry one extra bit so "full" (== DEPTH) is representable.
    localparam int PTR_W = IDX_W + 1;

    localparam logic [1:0] K_GPR = 2'd0;
    localparam logic [1:0] K_HI  = 2'd1;
    localparam logic [1:0] K_LO  = 2'd2;
    localparam logic [1:0] K_END = 2'd3;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_MISM  = 2'd1;
    localparam logic [1:0] C_EXTRA = 2'd2;
    localparam logic [1:0] C_TMO   = 2'd3;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t           state;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [TO_W-1:0]  tcnt;

    // Per-cycle event list, compacted in GPR, HI, LO order.
    logic              gpr_ev;
    logic [1:0]        n_ev;
    logic              ev_vld  [3];
    logic [1:0]        ev_kind [3];
    logic [ADDR_W-1:0] ev_addr [3];
    logic [DATA_W-1:0] ev_data [3];

    // Trace slots each event is compared against.
    logic [PTR_W-1:0]  ent_ptr [3];
    entry_t            ent     [3];

    // First failing comparison in this cycle, if any.
    logic              chk_fail;
    logic [1:0]        chk_cause;
    logic [IDX_W-1:0]  chk_idx;
    logic [DATA_W-1:0] chk_got;
    logic [DATA_W-1:0] chk_exp;

    logic              full;
    logic              at_end;
    logic              mem_we;

    assign full   = (wptr == PTR_W'(DEPTH));
    // rptr==wptr is checked first so the (possibly wrapped) read never matters then.
    assign at_end = (rptr == wptr) || (mem[rptr[IDX_W-1:0]].kind == K_END);
    assign mem_we = !rst && (state == S_IDLE) && load_we && !full;

    // Build the event list; writes to $0 never count as events.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ev_vld[k]  = 1'b0;
            ev_kind[k] = K_GPR;
            ev_addr[k] = '0;
            ev_data[k] = '0;
        end
        gpr_ev = wb_wreg && (wb_wd != '0);
        n_ev   = {1'b0, gpr_ev} + (wb_whilo ? 2'd2 : 2'd0);
        if (gpr_ev) begin
            ev_vld[0]  = 1'b1;
            ev_kind[0] = K_GPR;
            ev_addr[0] = wb_wd;
            ev_data[0] = wb_wdata;
            if (wb_whilo) begin
                ev_vld[1]  = 1'b1;
                ev_kind[1] = K_HI;
                ev_data[1] = wb_hi;
                ev_vld[2]  = 1'b1;
                ev_kind[2] = K_LO;
                ev_data[2] = wb_lo;
            end
        end else if (wb_whilo) begin
            ev_vld[0]  = 1'b1;
            ev_kind[0] = K_HI;
            ev_data[0] = wb_hi;
            ev_vld[1]  = 1'b1;
            ev_kind[1] = K_LO;
            ev_data[1] = wb_lo;
        end
    end

    // Look up the trace slots rptr, rptr+1, rptr+2.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ent_ptr[k] = rptr + PTR_W'(k);
            ent[k]     = mem[ent_ptr[k][IDX_W-1:0]];
        end
    end

    // Compare events against the trace; the lowest failing k wins.
    always_comb begin
        chk_fail  = 1'b0;
        chk_cause = C_NONE;
        chk_idx   = '0;
        chk_got   = '0;
        chk_exp   = '0;
        for (int k = 0; k < 3; k++) begin
            if (!chk_fail && ev_vld[k]) begin
                if ((ent_ptr[k] >= wptr) || (ent[k].kind == K_END)) begin
                    chk_fail  = 1'b1;
                    chk_cause = C_EXTRA;
                    chk_idx   = ent_ptr[k][IDX_W-1:0];
                    chk_got   = ev_data[k];
                    chk_exp   = '0;
                end else if ((ent[k].kind != ev_kind[k]) ||
                             (ent[k].data != ev_data[k]) ||
                             ((ev_kind[k] == K_GPR) && (ent[k].addr != ev_addr[k]))) begin
                    chk_fail  = 1'b1;
                    chk_cause = C_MISM;
                    chk_idx   = ent_ptr[k][IDX_W-1:0];
                    chk_got   = ev_data[k];
                    chk_exp   = ent[k].data;
                end
            end
        end
    end

    // Trace storage: not reset, only reachable below wptr.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr[IDX_W-1:0]] <= entry_t'(load_data);
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            tcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            load_ovf   <= 1'b0;
            fail_cause <= C_NONE;
            fail_idx   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_we) begin
                        if (full) load_ovf <= 1'b1;
                        else      wptr     <= wptr + 1'b1;
                    end
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        rptr  <= '0;
                        tcnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (chk_fail) begin
                        state      <= S_FAIL;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fail_cause <= chk_cause;
                        fail_idx   <= chk_idx;
                        fail_got   <= chk_got;
                        fail_exp   <= chk_exp;
                    end else if (n_ev != 2'd0) begin
                        rptr <= rptr + PTR_W'(n_ev);
                        tcnt <= '0;
                    end else if (at_end) begin
                        state <= S_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th consecutive idle cycle.
                        state      <= S_FAIL;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fail_cause <= C_TMO;
                        fail_idx   <= rptr[IDX_W-1:0];
                        fail_got   <= '0;
                        fail_exp   <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    // PASS / FAIL: hold results until restarted.
                    if (start) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_cause <= C_NONE;
                        fail_idx   <= '0;
                        fail_got   <= '0;
                        fail_exp   <= '0;
                        rptr       <= '0;
                        tcnt       <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker (TIMEOUT=8, DEPTH=64).
module tb_wb_trace_checker;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IDX_W  = 6;
    localparam int ENT_W  = 2 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_we;
    logic [ENT_W-1:0]  load_data;
    logic              start;
    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              busy, done, pass, load_ovf;
    logic [1:0]        fail_cause;
    logic [IDX_W-1:0]  fail_idx;
    logic [DATA_W-1:0] fail_got, fail_exp;

    int n_cmp = 0;
    int n_bad = 0;

    wb_trace_checker #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(64), .IDX_W(6), .TIMEOUT(8), .TO_W(9)
    ) dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_data(load_data),
        .start(start), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .busy(busy), .done(done), .pass(pass), .load_ovf(load_ovf),
        .fail_cause(fail_cause), .fail_idx(fail_idx),
        .fail_got(fail_got), .fail_exp(fail_exp)
    );

    always #5 clk = ~clk;

    function automatic logic [ENT_W-1:0] ent(input logic [1:0] k, input logic [4:0] a,
                                             input logic [31:0] d);
        return {k, a, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [ENT_W-1:0] e);
        load_we   = 1'b1;
        load_data = e;
        cyc();
        load_we   = 1'b0;
    endtask

    task automatic gpr(input logic [4:0] a, input logic [31:0] d);
        wb_wreg  = 1'b1;
        wb_wd    = a;
        wb_wdata = d;
        cyc();
        wb_wreg  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_we = 0; load_data = '0; start = 0;
        wb_wreg = 0; wb_wd = '0; wb_wdata = '0; wb_whilo = 0; wb_hi = '0; wb_lo = '0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_ovf", load_ovf, 0);
        chk("rst_cause", fail_cause, 0);

        // 1: in-order GPR writes with gaps -> PASS
        load(ent(0, 1, 1)); load(ent(0, 1, 2)); load(ent(0, 3, 5)); load(ent(3, 0, 0));
        do_start();
        chk("t1_busy", busy, 1);
        gpr(1, 1); idle(2);
        gpr(1, 2); idle(4);
        gpr(3, 5);
        chk("t1_done_early", done, 0);
        idle(1);
        chk("t1_pass", pass, 1);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_cause", fail_cause, 0);

        // 2: restart on the same trace, wrong r3 data -> mismatch
        do_start();
        chk("t2_restart_done", done, 0);
        chk("t2_restart_pass", pass, 0);
        gpr(1, 1); gpr(1, 2); idle(1);
        gpr(3, 6);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
        chk("t2_cause", fail_cause, 1);
        chk("t2_idx", fail_idx, 2);
        chk("t2_got", fail_got, 6);
        chk("t2_exp", fail_exp, 5);

        // 3a: GPR + HI + LO in one cycle -> all consumed, PASS
        do_rst();
        load(ent(0, 1, 3)); load(ent(1, 0, 2)); load(ent(2, 0, 32'hE)); load(ent(3, 0, 0));
        do_start();
        wb_wreg = 1; wb_wd = 1; wb_wdata = 3; wb_whilo = 1; wb_hi = 2; wb_lo = 32'hE;
        cyc();
        wb_wreg = 0; wb_whilo = 0;
        chk("t3_done_early", done, 0);
        idle(1);
        chk("t3_pass", pass, 1);

        // 3b: HI before GPR in trace -> mismatch at index 0
        do_rst();
        load(ent(1, 0, 2)); load(ent(0, 1, 3)); load(ent(2, 0, 32'hE)); load(ent(3, 0, 0));
        do_start();
        wb_wreg = 1; wb_wd = 1; wb_wdata = 3; wb_whilo = 1; wb_hi = 2; wb_lo = 32'hE;
        cyc();
        wb_wreg = 0; wb_whilo = 0;
        chk("t3b_cause", fail_cause, 1);
        chk("t3b_idx", fail_idx, 0);
        chk("t3b_got", fail_got, 3);
        chk("t3b_exp", fail_exp, 2);

        // 4: no events -> timeout after 8 idle cycles
        do_rst();
        load(ent(0, 1, 1)); load(ent(3, 0, 0));
        do_start();
        idle(7);
        chk("t4_busy_7", busy, 1);
        chk("t4_done_7", done, 0);
        idle(1);
        chk("t4_done", done, 1);
        chk("t4_cause", fail_cause, 3);
        chk("t4_idx", fail_idx, 0);
        chk("t4_got", fail_got, 0);

        // 5: $0 write ignored, then extra event past END
        do_rst();
        load(ent(0, 1, 1)); load(ent(3, 0, 0));
        do_start();
        gpr(0, 32'h55);
        chk("t5_r0_ignored", done, 0);
        gpr(1, 1);
        gpr(2, 32'hAB);
        chk("t5_cause", fail_cause, 2);
        chk("t5_idx", fail_idx, 1);
        chk("t5_got", fail_got, 32'hAB);
        chk("t5_exp", fail_exp, 0);

        // 6: overflow, then reset mid-RUN, then cold behaviour
        do_rst();
        for (int i = 0; i < 64; i++) load(ent(0, 1, 32'(i)));
        chk("t6_ovf_full", load_ovf, 0);
        load(ent(0, 1, 32'h99));
        chk("t6_ovf", load_ovf, 1);
        do_start();
        gpr(1, 0); gpr(1, 1);
        chk("t6_run_busy", busy, 1);
        do_rst();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovf", load_ovf, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_cause", fail_cause, 0);
        do_start();
        idle(1);
        chk("t6_empty_pass", pass, 1);
        do_rst();
        load(ent(0, 2, 7)); load(ent(3, 0, 0));
        do_start();
        gpr(2, 7); idle(1);
        chk("t6_cold_pass", pass, 1);
        chk("t6_cold_cause", fail_cause, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
